prbs9_checker: RTL and testbench
================================

PRBS9_CHECKER -- requirements
Module: prbs9_checker

Interface
REQ-001 Parameter LOCK_MATCHES, default 16: consecutive correct predictions required to declare lock.
REQ-002 Parameter WINDOW, default 64: accepted samples per lock-loss evaluation window.
REQ-003 Parameter LOSS_THRESH, default 8: errors within one window that force loss of lock.
REQ-004 Parameter CNT_W, default 32: width of bit_count and error_count.
REQ-005 clk  input  1  sole clock; all flops on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; asserted (low) forces the reset state immediately.
REQ-007 enable  input  1  block enable.
REQ-008 valid  input  1  bit_in qualifier; a sample is accepted only when enable and valid are both 1.
REQ-009 bit_in  input  1  received serial PRBS9 bit, one per accepted sample.
REQ-010 clear  input  1  synchronous counter clear.
REQ-011 locked  output  1  registered; 1 while state is LOCKED.
REQ-012 err_pulse  output  1  registered one-cycle error strobe.
REQ-013 bit_count  output  CNT_W  accepted samples checked while LOCKED.
REQ-014 error_count  output  CNT_W  mismatches detected while LOCKED.

Function
REQ-015 The sequence SHALL be x^9+x^5+1, recurrence o[n] = o[n-9] XOR o[n-5].
REQ-016 History register hist[8:0] SHALL hold the last 9 sequence bits, hist[0] the newest; prediction = hist[8] XOR hist[4].
REQ-017 Non-accepted cycles SHALL change no state, counter or output, except err_pulse returning to 0 and clear taking effect.
REQ-018 States SHALL be FILL, SEARCH and LOCKED; reset state is FILL.
REQ-019 FILL: each accepted bit_in shifts into hist; after the 9th accepted sample the state becomes SEARCH, with the match counter at 0.
REQ-020 SEARCH: each accepted sample compares bit_in to the prediction and shifts bit_in into hist; a match increments the match counter, a mismatch resets it to 0.
REQ-021 SEARCH -> LOCKED on the accepted sample that brings the match counter to LOCK_MATCHES; locked SHALL be 1 from the following cycle.
REQ-022 LOCKED: each accepted sample SHALL shift the prediction (not bit_in) into hist, so one line error counts exactly once.
REQ-023 LOCKED: each accepted sample increments bit_count; a mismatch also increments error_count and the window error count, and sets err_pulse to 1 for the next cycle only.
REQ-024 bit_count and error_count SHALL saturate at all-ones.
REQ-025 The window counter SHALL count accepted LOCKED samples; after the WINDOW-th sample both the window counter and the window error count reset to 0, with that sample included in the ending window.
REQ-026 LOCKED -> FILL on the accepted mismatch that brings the window error count to LOSS_THRESH; locked SHALL be 0 from the next cycle; bit_count and error_count hold; the fill, match and window counters clear.
REQ-027 clear=1 SHALL set bit_count and error_count to 0 on the next edge, overriding a same-cycle increment; state, hist and err_pulse are unaffected.
REQ-028 An all-zero input locks and checks as error-free; this is required behaviour, not an error.

Reset
REQ-029 rst low SHALL asynchronously set the state to FILL; hist, the match, fill and window counters, bit_count and error_count to 0; and locked and err_pulse to 0.
REQ-030 Release of rst SHALL be treated as synchronous to clk; the first accepted sample after release is fill bit 1.

Structure
REQ-031 Package prbs_pkg SHALL hold the PRBS9 tap constants (9, 5), the state encoding and the parameter defaults, shared with the generator.
REQ-032 One sub-module, sat_counter (CNT_W, inc, clr), SHALL implement both output counters.

Verification
REQ-033 Generator SEED=9'h1FF drives bit_in with valid=1: locked rises the cycle after accepted sample 25; after 511 further samples, bit_count=511 and error_count=0.
REQ-034 Locked, flip one bit: error_count=1 (not 3), err_pulse high for exactly one cycle, locked stays 1.
REQ-035 Locked, flip 7 bits within one 64-sample window: locked stays 1. Flip 8 bits: locked falls the cycle after the 8th flip, and relock occurs after 25 further clean samples.
REQ-036 Random valid/enable gaps on a clean stream: same lock point counted in accepted samples; gap cycles change nothing.
REQ-037 rst low mid-LOCKED with bit_count=100: all outputs 0 immediately; relock needs 25 accepted samples.
REQ-038 clear=1 in the same cycle as an accepted mismatch: error_count=0 and bit_count=0 next cycle; err_pulse=1.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS9 definitions: polynomial taps, checker state encoding and
// parameter defaults used by both the generator and the checker.
package prbs_pkg;

  localparam int PRBS_LEN = 9;
  localparam int PRBS_TAP = 5;

  localparam int LOCK_MATCHES_DEF = 16;
  localparam int WINDOW_DEF       = 64;
  localparam int LOSS_THRESH_DEF  = 8;
  localparam int CNT_W_DEF        = 32;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  // Next sequence bit from a 9-bit history, hist[0] newest.
  function automatic logic prbs9_predict(input logic [PRBS_LEN-1:0] hist);
    return hist[PRBS_LEN-1] ^ hist[PRBS_TAP-1];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/prbs9_checker.sv
// PRBS9 (x^9+x^5+1) receive checker: fills a history, searches for a run of
// correct predictions, then free-runs and counts bit errors until lock loss.
module prbs9_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_MATCHES = LOCK_MATCHES_DEF,
  parameter int WINDOW       = WINDOW_DEF,
  parameter int LOSS_THRESH  = LOSS_THRESH_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             valid,
  input  logic             bit_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] error_count
);

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  localparam logic [3:0]    FILL_LAST  = 4'(PRBS_LEN - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(LOSS_THRESH - 1);

  prbs_state_e         r_state, w_state_nxt;
  logic [PRBS_LEN-1:0] r_hist, w_hist_nxt;
  logic [3:0]          r_fill, w_fill_nxt;
  logic [MW-1:0]       r_match, w_match_nxt;
  logic [WW-1:0]       r_win, w_win_nxt;
  logic [EW-1:0]       r_werr, w_werr_nxt;
  logic                r_locked, r_err_pulse;

  logic w_accept, w_pred, w_mismatch, w_bit_inc, w_err_inc;

  assign w_accept   = enable & valid;
  assign w_pred     = prbs9_predict(r_hist);
  assign w_mismatch = bit_in ^ w_pred;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_FILL;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_match_nxt = r_match;
    w_win_nxt   = r_win;
    w_werr_nxt  = r_werr;
    w_bit_inc   = 1'b0;
    w_err_inc   = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        ST_FILL: begin
          w_hist_nxt = {r_hist[PRBS_LEN-2:0], bit_in};
          if (r_fill == FILL_LAST) begin
            w_fill_nxt  = '0;
            w_match_nxt = '0;
            w_state_nxt = ST_SEARCH;
          end else begin
            w_fill_nxt = r_fill + 4'd1;
          end
        end
        ST_SEARCH: begin
          w_hist_nxt = {r_hist[PRBS_LEN-2:0], bit_in};
          if (w_mismatch) begin
            w_match_nxt = '0;
          end else if (r_match == MATCH_LAST) begin
            w_match_nxt = '0;
            w_win_nxt   = '0;
            w_werr_nxt  = '0;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_match_nxt = r_match + MW'(1);
          end
        end
        ST_LOCKED: begin
          // Free-run on our own prediction so a line error cannot propagate.
          w_hist_nxt = {r_hist[PRBS_LEN-2:0], w_pred};
          w_bit_inc  = 1'b1;
          w_err_inc  = w_mismatch;
          if (w_mismatch && (r_werr == ERR_LAST)) begin
            w_fill_nxt  = '0;
            w_match_nxt = '0;
            w_win_nxt   = '0;
            w_werr_nxt  = '0;
            w_state_nxt = ST_FILL;
          end else if (r_win == WIN_LAST) begin
            w_win_nxt  = '0;
            w_werr_nxt = '0;
          end else begin
            w_win_nxt  = r_win + WW'(1);
            w_werr_nxt = r_werr + EW'(w_mismatch);
          end
        end
        default: w_state_nxt = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win       <= '0;
      r_werr      <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_hist      <= w_hist_nxt;
      r_fill      <= w_fill_nxt;
      r_match     <= w_match_nxt;
      r_win       <= w_win_nxt;
      r_werr      <= w_werr_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_err_pulse <= w_err_inc;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (w_bit_inc),
    .clr   (clear),
    .count (bit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (w_err_inc),
    .clr   (clear),
    .count (error_count)
  );

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_prbs9_checker.sv
// Scoreboard bench for prbs9_checker: a driver issues directed samples and
// queues expected outputs; a monitor pops and compares after each edge.
module tb_prbs9_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clear = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [31:0] bit_count;
  logic [31:0] error_count;

  prbs9_checker dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .valid       (valid),
    .bit_in      (bit_in),
    .clear       (clear),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .bit_count   (bit_count),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  localparam int SEL_LOCK = 0, SEL_PULSE = 1, SEL_BITS = 2, SEL_ERRS = 3;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         last_tag = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] gen = 9'h1FF;
  bit         zero_mode = 1'b0;

  task automatic check(input string name, input int sel, input logic [31:0] val);
    logic [31:0] act;
    case (sel)
      SEL_LOCK:  act = 32'(locked);
      SEL_PULSE: act = 32'(err_pulse);
      SEL_BITS:  act = bit_count;
      default:   act = error_count;
    endcase
    n_checks++;
    if (act !== val) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, val);
    end
  endtask

  // Monitor: compare every queued expectation tagged for this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check(e.name, e.sel, e.val);
      end
    end
  end

  task automatic push_exp(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.cyc  = last_tag;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus; the generator advances only on accepted samples.
  task automatic step(input bit en, input bit vl, input bit flip, input bit clr);
    logic nb;
    @(negedge clk);
    enable = en;
    valid  = vl;
    clear  = clr;
    if (en && vl) begin
      nb     = zero_mode ? 1'b0 : (gen[8] ^ gen[4]);
      bit_in = nb ^ flip;
      gen    = {gen[7:0], nb};
    end else begin
      bit_in = 1'($urandom_range(0, 1));
    end
    last_tag = cyc + 1;
  endtask

  task automatic clean(input int n);
    repeat (n) step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    @(negedge clk);
    enable = 1'b0;
    valid  = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    idle();
    #2 rst = 1'b0;
    #1;
    check({tag, "_locked"}, SEL_LOCK, 32'd0);
    check({tag, "_err_pulse"}, SEL_PULSE, 32'd0);
    check({tag, "_bit_count"}, SEL_BITS, 32'd0);
    check({tag, "_error_count"}, SEL_ERRS, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int acc;
    int g;
    repeat (2) @(negedge clk);
    #1;
    check("reset_locked", SEL_LOCK, 32'd0);
    check("reset_err_pulse", SEL_PULSE, 32'd0);
    check("reset_bit_count", SEL_BITS, 32'd0);
    check("reset_error_count", SEL_ERRS, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Clean seeded stream: lock on sample 25, then 511 checked samples.
    clean(24);
    push_exp("lock_pre_25", SEL_LOCK, 32'd0);
    push_exp("search_no_count", SEL_BITS, 32'd0);
    clean(1);
    push_exp("lock_at_25", SEL_LOCK, 32'd1);
    clean(511);
    push_exp("clean_bit_count", SEL_BITS, 32'd511);
    push_exp("clean_error_count", SEL_ERRS, 32'd0);
    push_exp("clean_locked", SEL_LOCK, 32'd1);

    // Single line error counts once.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    push_exp("single_err_pulse", SEL_PULSE, 32'd1);
    push_exp("single_err_count", SEL_ERRS, 32'd1);
    push_exp("single_bit_count", SEL_BITS, 32'd512);
    clean(1);
    push_exp("single_pulse_drop", SEL_PULSE, 32'd0);
    push_exp("single_err_no_echo", SEL_ERRS, 32'd1);
    clean(63);
    push_exp("single_err_once", SEL_ERRS, 32'd1);
    push_exp("single_still_locked", SEL_LOCK, 32'd1);

    // Seven errors in one window keep lock.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      clean(1);
    end
    push_exp("seven_errs_locked", SEL_LOCK, 32'd1);
    push_exp("seven_errs_count", SEL_ERRS, 32'd8);
    clean(50);
    push_exp("seven_window_end_locked", SEL_LOCK, 32'd1);

    // Eight errors in one window drop lock.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 6) push_exp("loss_pre_8th", SEL_LOCK, 32'd1);
      if (i < 7) clean(1);
    end
    push_exp("loss_on_8th", SEL_LOCK, 32'd0);
    push_exp("loss_err_pulse", SEL_PULSE, 32'd1);
    push_exp("loss_err_count", SEL_ERRS, 32'd16);
    clean(24);
    push_exp("relock_pre_25", SEL_LOCK, 32'd0);
    push_exp("loss_bit_hold", SEL_BITS, 32'd655);
    push_exp("loss_err_hold", SEL_ERRS, 32'd16);
    clean(1);
    push_exp("relock_at_25", SEL_LOCK, 32'd1);

    // Clear overrides a same-cycle mismatch increment.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    push_exp("clear_err_count", SEL_ERRS, 32'd0);
    push_exp("clear_bit_count", SEL_BITS, 32'd0);
    push_exp("clear_err_pulse", SEL_PULSE, 32'd1);
    push_exp("clear_locked", SEL_LOCK, 32'd1);
    clean(100);
    push_exp("pre_reset_bit_count", SEL_BITS, 32'd100);
    push_exp("pre_reset_err_count", SEL_ERRS, 32'd0);

    async_reset("rst_mid_lock");

    // Relock with valid/enable gaps; gaps must not move anything.
    acc = 0;
    while (acc < 25) begin
      g = int'($urandom_range(0, 3));
      if (g == 0) begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
        if (acc == 24) push_exp("gap_hold_unlocked", SEL_LOCK, 32'd0);
      end else if (g == 1) begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        if (acc == 24) push_exp("gap_hold_unlocked", SEL_LOCK, 32'd0);
      end else begin
        step(1'b1, 1'b1, 1'b0, 1'b0);
        acc++;
        if (acc == 24) push_exp("gap_lock_pre_25", SEL_LOCK, 32'd0);
        if (acc == 25) push_exp("gap_lock_at_25", SEL_LOCK, 32'd1);
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("gap_locked_hold", SEL_LOCK, 32'd1);
    push_exp("gap_no_count", SEL_BITS, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    push_exp("gap_bit_count", SEL_BITS, 32'd10);
    push_exp("gap_err_count", SEL_ERRS, 32'd0);
    push_exp("gap_err_pulse", SEL_PULSE, 32'd0);

    // All-zero input is a legal, error-free stream.
    async_reset("rst_zero");
    zero_mode = 1'b1;
    clean(24);
    push_exp("zero_pre_lock", SEL_LOCK, 32'd0);
    clean(1);
    push_exp("zero_lock", SEL_LOCK, 32'd1);
    clean(5);
    push_exp("zero_bit_count", SEL_BITS, 32'd5);
    push_exp("zero_err_count", SEL_ERRS, 32'd0);

    idle();
    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
